// File: rtl/ofmap_writer.sv
// ofmap_writer -- output feature-map writer at the tail of the CNN scan.
//
// Takes the conv engine's result stream and writes it row-major into the
// output feature-map SRAM as a size x size map. Owns the write address,
// row/col tracking, end-of-map detection and framing-error checking.
//
// Optional feature macro: OFMAP_WRITER_RELU_EN
//   defined   -> negative results are written as 0 (fused ReLU)
//   undefined -> results are written unchanged
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   size                map side length, captured when a map starts
//   start               begin a new map (honoured in IDLE only)
//   clear               synchronous abort to IDLE, drops a same-cycle beat
//   in_valid/in_ready   result handshake; in_data, in_last travel with it
//   wr_en/wr_addr/wr_data  registered SRAM write port
//   row, col            position of the most recent write
//   busy                map in progress
//   done                one-cycle pulse, coincides with the final write
//   err                 sticky framing error (in_last misplaced or missing)
module ofmap_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        size,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        row,
    output logic [7:0]        col,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        size_q;
    logic [7:0]        row_cnt, col_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              fire, take, final_beat, start_ok;
    logic [DATA_W-1:0] data_out;

    assign in_ready   = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign fire       = in_valid && in_ready;
    // a beat accepted alongside clear is dropped
    assign take       = fire && !clear;
    assign start_ok   = (state == IDLE) && start && !clear;
    // size_q is never 0 while in RUN, so size_q-1 does not underflow there
    assign final_beat = (row_cnt == size_q - 8'd1) && (col_cnt == size_q - 8'd1);

`ifdef OFMAP_WRITER_RELU_EN
    assign data_out = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign data_out = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = (size == 8'd0) ? DONE : RUN;
                RUN:     if (fire && final_beat) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // scan counters: addr runs linearly, row/col track it without a multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q   <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            addr_cnt <= '0;
        end else if (start_ok) begin
            size_q   <= size;
            row_cnt  <= '0;
            col_cnt  <= '0;
            addr_cnt <= '0;
        end else if (take) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (col_cnt == size_q - 8'd1) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 8'd1;
            end else begin
                col_cnt <= col_cnt + 8'd1;
            end
        end
    end

    // write port; address/data/position hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            wr_en <= take;
            if (take) begin
                wr_addr <= addr_cnt;
                wr_data <= data_out;
                row     <= row_cnt;
                col     <= col_cnt;
            end
        end
    end

    // framing error: in_last must appear on exactly the final beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err <= 1'b0;
        else if (clear || start_ok)         err <= 1'b0;
        else if (take && (in_last != final_beat)) err <= 1'b1;
    end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer. Inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_ofmap_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  size;
    logic        start, clear, in_valid, in_last;
    logic [15:0] in_data;
    logic        in_ready, wr_en, busy, done, err;
    logic [15:0] wr_addr, wr_data;
    logic [7:0]  row, col;

    int n_chk = 0;
    int n_bad = 0;

`ifdef OFMAP_WRITER_RELU_EN
    localparam logic [15:0] NEG5_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG5_EXP = 16'hFFFB;
`endif

    always #5 clk = ~clk;

    ofmap_writer #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .size(size), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .row(row), .col(col), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one beat, advance one cycle, check the resulting write
    task automatic beat(input logic [15:0] d, input logic l, input int a,
                        input int r, input int c, input logic [15:0] wd, input logic dn);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        chk("wr_en",   wr_en,   1);
        chk("wr_addr", wr_addr, a);
        chk("row",     row,     r);
        chk("col",     col,     c);
        chk("wr_data", wr_data, wd);
        chk("done",    done,    dn);
    endtask

    task automatic go(input logic [7:0] s);
        start = 1'b1; size = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; size = 0; start = 0; clear = 0;
        in_valid = 0; in_data = 0; in_last = 0;
        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst wr_en",    wr_en,    0);
        chk("rst wr_addr",  wr_addr,  0);
        chk("rst wr_data",  wr_data,  0);
        chk("rst row",      row,      0);
        chk("rst col",      col,      0);
        chk("rst busy",     busy,     0);
        chk("rst done",     done,     0);
        chk("rst err",      err,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid while IDLE is not consumed
        in_valid = 1'b1; in_data = 16'h55;
        @(negedge clk);
        chk("idle in_ready", in_ready, 0);
        chk("idle wr_en",    wr_en,    0);
        in_valid = 1'b0;

        // 1: size 3, back-to-back, size input changed mid-map
        go(8'd3);
        size = 8'd7;
        chk("t1 busy",     busy,     1);
        chk("t1 in_ready", in_ready, 1);
        for (int i = 0; i < 9; i++)
            beat(16'(i + 1), i == 8, i, i / 3, i % 3, 16'(i + 1), i == 8);
        in_valid = 1'b0; in_last = 1'b0;
        chk("t1 busy end", busy, 0);
        chk("t1 err",      err,  0);
        @(negedge clk);
        chk("t1 done off", done,  0);
        chk("t1 wr_en off", wr_en, 0);

        // 2: size 4, valid toggling; a start mid-map is ignored
        go(8'd4);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin start = 1'b1; size = 8'd9; end
            beat(16'(100 + i), i == 15, i, i / 4, i % 4, 16'(100 + i), i == 15);
            start = 1'b0;
            in_valid = 1'b0; in_last = 1'b0;
            @(negedge clk);
            chk("t2 gap wr_en", wr_en, 0);
            chk("t2 gap done",  done,  0);
        end
        chk("t2 err", err, 0);

        // 3: size 2, early in_last
        go(8'd2);
        beat(16'd11, 1'b0, 0, 0, 0, 16'd11, 1'b0);
        chk("t3 err b1", err, 0);
        beat(16'd12, 1'b1, 1, 0, 1, 16'd12, 1'b0);
        chk("t3 err b2", err, 1);
        beat(16'd13, 1'b0, 2, 1, 0, 16'd13, 1'b0);
        beat(16'd14, 1'b0, 3, 1, 1, 16'd14, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3 err sticky", err,  1);
        chk("t3 idle busy",  busy, 0);

        // 4: size 0 -> done pulse, no writes, err cleared by start
        go(8'd0);
        chk("t4 done",  done,  1);
        chk("t4 wr_en", wr_en, 0);
        chk("t4 busy",  busy,  0);
        chk("t4 err",   err,   0);
        @(negedge clk);
        chk("t4 done off", done, 0);

        // 5: size 5, clear with a valid beat after 7 writes
        go(8'd5);
        for (int i = 0; i < 7; i++)
            beat(16'(200 + i), 1'b0, i, i / 5, i % 5, 16'(200 + i), 1'b0);
        in_data = 16'd99; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("t5 clr wr_en", wr_en,   0);
        chk("t5 clr busy",  busy,    0);
        chk("t5 clr addr",  wr_addr, 6);
        @(negedge clk);
        chk("t5 idle wr_en", wr_en, 0);
        // clear wins over start
        start = 1'b1; clear = 1'b1; size = 8'd3;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("t5 clr>start busy", busy, 0);
        chk("t5 clr>start done", done, 0);
        go(8'd1);
        beat(16'd77, 1'b1, 0, 0, 0, 16'd77, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        chk("t5 err", err, 0);
        @(negedge clk);

        // 6: negative data, then async reset mid-map
        go(8'd2);
        beat(16'hFFFB, 1'b0, 0, 0, 0, NEG5_EXP, 1'b0);
        beat(16'd5, 1'b0, 1, 0, 1, 16'd5, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst wr_en",    wr_en,    0);
        chk("t6 rst wr_addr",  wr_addr,  0);
        chk("t6 rst wr_data",  wr_data,  0);
        chk("t6 rst row",      row,      0);
        chk("t6 rst col",      col,      0);
        chk("t6 rst busy",     busy,     0);
        chk("t6 rst in_ready", in_ready, 0);
        chk("t6 rst done",     done,     0);
        chk("t6 rst err",      err,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6 post busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
